fb_scanout: RTL and testbench
=============================

# fb_scanout

Parametrised framebuffer scan-out engine between `video_sig_gen` and the TMDS encoders. It maps screen coordinates to scaled framebuffer pixels, adds a tear-free scroll offset with wrap-around, and issues word reads to a fixed-latency memory port. It selects the pixel lane, expands RGB332 or RGB565 to RGB888 by bit replication, and delays sync and active signals so they stay aligned with colour.

## Interface
- `H_RES`, 320: framebuffer width in pixels.
- `V_RES`, 180: framebuffer height in pixels.
- `SCALE_LOG2`, 2: screen-to-framebuffer downscale, 0..3 (1x..8x).
- `BPP`, 8: 8 (RGB332, 4 px/word) or 16 (RGB565, 2 px/word); other values are an elaboration error.
- `FB_WORD_BASE`, 'h300: word address of framebuffer pixel 0.
- `ADDR_WIDTH`, 32: memory address width.
- `READ_LATENCY`, 2: cycles from a registered `mem_addr` to valid `mem_rdata`, ≥1.

Ports:
- `clk` in 1: pixel clock; sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `h_count` in 11, `v_count` in 10: screen coordinates.
- `active_draw`, `h_sync`, `v_sync`, `new_frame` in 1 each: timing from `video_sig_gen`.
- `scroll_x` in 16, `scroll_y` in 16, `scroll_wen` in 1: scroll offset write.
- `mem_addr` out ADDR_WIDTH: word read address.
- `mem_ren` out 1: read enable.
- `mem_rdata` in 32: read data.
- `red`, `green`, `blue` out 8 each: expanded colour.
- `active_draw_out`, `h_sync_out`, `v_sync_out` out 1 each: delayed timing.

## Operation
- Scroll registers:
  - `scroll_wen` with `scroll_x < H_RES` and `scroll_y < V_RES` loads the pending pair. An out-of-range write is ignored as a whole; pending is unchanged.
  - On `new_frame`, live ← pending.
  - If `scroll_wen` is valid in the same cycle as `new_frame`, live ← the written values (bypass) and pending ← the same values.
  - The live offset never changes mid-frame.
- Stage 0 (registered):
  - `sx = h_count >> SCALE_LOG2`, `sy = v_count >> SCALE_LOG2`.
  - `in_range = active_draw && sx < H_RES && sy < V_RES`.
  - `fb_x = sx + live_x`, minus `H_RES` once if the sum is ≥ `H_RES`. `fb_y` likewise with `V_RES`.
- Stage 1 (registered):
  - `p = fb_y*H_RES + fb_x`.
  - `mem_addr = FB_WORD_BASE + (p >> 2)` for BPP 8, or `(p >> 1)` for BPP 16.
  - `lane = p[1:0]` for BPP 8, or `p[0]` for BPP 16.
  - `mem_ren = in_range`.
  - `mem_addr` holds its last value when `mem_ren` is 0.
- Delay line: `lane`, `in_range`, `active_draw`, `h_sync` and `v_sync` are delayed `READ_LATENCY` cycles to meet `mem_rdata`.
- Stage 2 (registered output):
  - Lane 0 is the least significant byte or halfword.
  - RGB332: `r={d[7:5],d[7:5],d[7:6]}`, `g={d[4:2],d[4:2],d[4:3]}`, `b={d[1:0],d[1:0],d[1:0],d[1:0]}`.
  - RGB565: `r={d[15:11],d[15:13]}`, `g={d[10:5],d[10:9]}`, `b={d[4:0],d[4:2]}`.
  - Colour is 0 when the delayed `in_range` is 0, which covers both blanking and area outside the framebuffer.
- Reset: all pipeline registers, scroll live/pending, `mem_ren`, `mem_addr`, RGB and all `*_out` go to 0. Reset mid-line discards in-flight pixels; output is black and syncs are low until the pipeline refills.

## Timing
- Latency L = 3 + `READ_LATENCY` cycles from inputs to RGB/`*_out`; 5 at default parameters.
- `h_sync_out`, `v_sync_out` and `active_draw_out` are the inputs delayed exactly L cycles, with no other modification.
- Throughput is one pixel per clock with no stalls. `mem_rdata` is sampled exactly `READ_LATENCY` cycles after the `mem_addr`/`mem_ren` edge.
- `mem_ren` is asserted at the stage-1 output, 2 cycles after the corresponding inputs.
- A scroll change is visible from the first pixel of the frame that follows the `new_frame` pulse that applied it.

## Test plan
- **BPP 8 white pixel:** word 'h300 = 'h000000FF, h=v=0, active → `mem_addr`='h300 and `mem_ren`=1 at +2; RGB = 255,255,255 at +5.
- **BPP 8 lane select:** h_count=8 (sx=2), word 'h300 = 'h00E00000 → lane 2; RGB = 255,0,0.
- **BPP 16 lane select:** h_count=4, word = 'h07E0_0000 → lane 1; RGB = 0,255,0.
- **Scroll wrap:**
  - scroll_x=319 written, then `new_frame`; h_count=4 → fb_x=0, `mem_addr`='h300.
  - scroll_y=179; v_count=4 → fb_y=0.
  - A write mid-frame leaves the address unchanged until the next `new_frame`.
  - scroll_x=320 is ignored.
- **Out of range:** v_count=720 with active high (sy=180) → `mem_ren`=0 and RGB=0; `active_draw_out`=1 after L cycles.
- **Reset mid-line:** assert `rst` during active → all outputs 0 immediately. After release, the first correct pixel appears L cycles after the first in-range input.

Source files
------------

// File: rtl/fb_scanout.sv
// fb_scanout -- framebuffer scan-out engine.
//
// Maps screen coordinates to downscaled framebuffer pixels, applies a
// frame-synchronous scroll offset with wrap-around, issues word reads to a
// fixed-latency memory port, selects the pixel lane and expands RGB332 or
// RGB565 to RGB888 by bit replication.  Timing signals are delayed so that
// they stay aligned with colour; total latency is 3 + READ_LATENCY cycles.
//
// Ports:
//   clk, rst                      pixel clock, asynchronous active-high reset
//   h_count, v_count              screen coordinates
//   active_draw, h_sync, v_sync   timing from video_sig_gen
//   new_frame                     frame start pulse; applies pending scroll
//   scroll_x, scroll_y,
//   scroll_wen                    scroll offset write (ignored if out of range)
//   mem_addr, mem_ren             word read request (address holds when idle)
//   mem_rdata                     read data, READ_LATENCY cycles after request
//   red, green, blue              expanded RGB888 colour
//   active_draw_out, h_sync_out,
//   v_sync_out                    timing delayed to match colour
module fb_scanout #(
   parameter int unsigned H_RES        = 320,
   parameter int unsigned V_RES        = 180,
   parameter int unsigned SCALE_LOG2   = 2,
   parameter int unsigned BPP          = 8,
   parameter int unsigned FB_WORD_BASE = 'h300,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [10:0]           h_count,
   input  logic [9:0]            v_count,
   input  logic                  active_draw,
   input  logic                  h_sync,
   input  logic                  v_sync,
   input  logic                  new_frame,
   input  logic [15:0]           scroll_x,
   input  logic [15:0]           scroll_y,
   input  logic                  scroll_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_ren,
   input  logic [31:0]           mem_rdata,
   output logic [7:0]            red,
   output logic [7:0]            green,
   output logic [7:0]            blue,
   output logic                  active_draw_out,
   output logic                  h_sync_out,
   output logic                  v_sync_out
);

   if (BPP != 8 && BPP != 16) begin : g_bad_bpp
      $error("fb_scanout: BPP must be 8 or 16");
   end
   if (READ_LATENCY < 1) begin : g_bad_latency
      $error("fb_scanout: READ_LATENCY must be at least 1");
   end
   if (SCALE_LOG2 > 3) begin : g_bad_scale
      $error("fb_scanout: SCALE_LOG2 must be 0..3");
   end

   localparam logic [15:0]           H_RES_16 = 16'(H_RES);
   localparam logic [15:0]           V_RES_16 = 16'(V_RES);
   localparam logic [16:0]           H_RES_17 = 17'(H_RES);
   localparam logic [16:0]           V_RES_17 = 17'(V_RES);
   localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(FB_WORD_BASE);

   // ---------------------------------------------------------------
   // Scroll registers: pending is written any time, live only moves on
   // new_frame so the offset is constant across a frame.
   // ---------------------------------------------------------------
   logic        scroll_ok;
   logic [15:0] pend_x, pend_y, live_x, live_y;

   always_comb begin
      scroll_ok = scroll_wen && (scroll_x < H_RES_16) && (scroll_y < V_RES_16);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_x <= '0;
         pend_y <= '0;
         live_x <= '0;
         live_y <= '0;
      end else begin
         if (scroll_ok) begin
            pend_x <= scroll_x;
            pend_y <= scroll_y;
         end
         if (new_frame) begin
            // a valid write coinciding with new_frame bypasses pending
            live_x <= scroll_ok ? scroll_x : pend_x;
            live_y <= scroll_ok ? scroll_y : pend_y;
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 0: scale, range check, scroll with single wrap.
   // ---------------------------------------------------------------
   logic [10:0] sx;
   logic [9:0]  sy;
   logic [16:0] sum_x, sum_y, wrap_x, wrap_y;
   logic        in_range_c;

   always_comb begin
      sx         = h_count >> SCALE_LOG2;
      sy         = v_count >> SCALE_LOG2;
      in_range_c = active_draw && ({5'd0, sx} < H_RES_16) && ({6'd0, sy} < V_RES_16);
      sum_x      = {6'd0, sx} + {1'b0, live_x};
      sum_y      = {7'd0, sy} + {1'b0, live_y};
      wrap_x     = (sum_x >= H_RES_17) ? sum_x - H_RES_17 : sum_x;
      wrap_y     = (sum_y >= V_RES_17) ? sum_y - V_RES_17 : sum_y;
   end

   logic [15:0] s0_fb_x, s0_fb_y;
   logic        s0_in_range, s0_act, s0_hs, s0_vs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_fb_x     <= '0;
         s0_fb_y     <= '0;
         s0_in_range <= 1'b0;
         s0_act      <= 1'b0;
         s0_hs       <= 1'b0;
         s0_vs       <= 1'b0;
      end else begin
         s0_fb_x     <= 16'(wrap_x);
         s0_fb_y     <= 16'(wrap_y);
         s0_in_range <= in_range_c;
         s0_act      <= active_draw;
         s0_hs       <= h_sync;
         s0_vs       <= v_sync;
      end
   end

   // ---------------------------------------------------------------
   // Stage 1: linear pixel index -> word address and lane.
   // ---------------------------------------------------------------
   logic [31:0] pix, word_off;
   logic [1:0]  lane_c;

   always_comb begin
      pix = 32'(s0_fb_y) * H_RES + 32'(s0_fb_x);
      if (BPP == 8) begin
         word_off = pix >> 2;
         lane_c   = pix[1:0];
      end else begin
         word_off = pix >> 1;
         lane_c   = {1'b0, pix[0]};
      end
   end

   logic [1:0] s1_lane;
   logic       s1_act, s1_hs, s1_vs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr <= '0;
         mem_ren  <= 1'b0;
         s1_lane  <= '0;
         s1_act   <= 1'b0;
         s1_hs    <= 1'b0;
         s1_vs    <= 1'b0;
      end else begin
         if (s0_in_range) begin
            mem_addr <= BASE + ADDR_WIDTH'(word_off);
         end
         mem_ren <= s0_in_range;
         s1_lane <= lane_c;
         s1_act  <= s0_act;
         s1_hs   <= s0_hs;
         s1_vs   <= s0_vs;
      end
   end

   // ---------------------------------------------------------------
   // Delay line covering the memory read latency; mem_ren doubles as the
   // stage-1 in_range flag.
   // ---------------------------------------------------------------
   logic [1:0]              dl_lane [READ_LATENCY];
   logic [READ_LATENCY-1:0] dl_in_range, dl_act, dl_hs, dl_vs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            dl_lane[i] <= '0;
         end
         dl_in_range <= '0;
         dl_act      <= '0;
         dl_hs       <= '0;
         dl_vs       <= '0;
      end else begin
         dl_lane[0]     <= s1_lane;
         dl_in_range[0] <= mem_ren;
         dl_act[0]      <= s1_act;
         dl_hs[0]       <= s1_hs;
         dl_vs[0]       <= s1_vs;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            dl_lane[i]     <= dl_lane[i-1];
            dl_in_range[i] <= dl_in_range[i-1];
            dl_act[i]      <= dl_act[i-1];
            dl_hs[i]       <= dl_hs[i-1];
            dl_vs[i]       <= dl_vs[i-1];
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: lane select and colour expansion.
   // ---------------------------------------------------------------
   logic [1:0]  lane_d;
   logic [7:0]  px8;
   logic [15:0] px16;
   logic [7:0]  r_c, g_c, b_c;

   always_comb begin
      lane_d = dl_lane[READ_LATENCY-1];
      case (lane_d)
         2'd0:    px8 = mem_rdata[7:0];
         2'd1:    px8 = mem_rdata[15:8];
         2'd2:    px8 = mem_rdata[23:16];
         default: px8 = mem_rdata[31:24];
      endcase
      px16 = lane_d[0] ? mem_rdata[31:16] : mem_rdata[15:0];
      if (BPP == 8) begin
         r_c = {px8[7:5], px8[7:5], px8[7:6]};
         g_c = {px8[4:2], px8[4:2], px8[4:3]};
         b_c = {px8[1:0], px8[1:0], px8[1:0], px8[1:0]};
      end else begin
         r_c = {px16[15:11], px16[15:13]};
         g_c = {px16[10:5], px16[10:9]};
         b_c = {px16[4:0], px16[4:2]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red             <= '0;
         green           <= '0;
         blue            <= '0;
         active_draw_out <= 1'b0;
         h_sync_out      <= 1'b0;
         v_sync_out      <= 1'b0;
      end else begin
         red             <= dl_in_range[READ_LATENCY-1] ? r_c : '0;
         green           <= dl_in_range[READ_LATENCY-1] ? g_c : '0;
         blue            <= dl_in_range[READ_LATENCY-1] ? b_c : '0;
         active_draw_out <= dl_act[READ_LATENCY-1];
         h_sync_out      <= dl_hs[READ_LATENCY-1];
         v_sync_out      <= dl_vs[READ_LATENCY-1];
      end
   end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout -- directed self-checking bench for fb_scanout.
// Two instances share the timing/scroll inputs and one word memory:
// dut8 uses RGB332 (default parameters), dut16 uses RGB565.
module tb_fb_scanout;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] h_count;
   logic [9:0]  v_count;
   logic        active_draw, h_sync, v_sync, new_frame;
   logic [15:0] scroll_x, scroll_y;
   logic        scroll_wen;

   logic [31:0] addr8, addr16;
   logic        ren8, ren16;
   logic [31:0] rdata8, rdata16;
   logic [7:0]  r8, g8, b8, r16, g16, b16;
   logic        act8, hs8, vs8, act16, hs16, vs16;

   logic [31:0] mem [32768];
   logic [31:0] pipe8_0, pipe8_1, pipe16_0, pipe16_1;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fb_scanout dut8 (
      .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
      .active_draw(active_draw), .h_sync(h_sync), .v_sync(v_sync),
      .new_frame(new_frame), .scroll_x(scroll_x), .scroll_y(scroll_y),
      .scroll_wen(scroll_wen), .mem_addr(addr8), .mem_ren(ren8),
      .mem_rdata(rdata8), .red(r8), .green(g8), .blue(b8),
      .active_draw_out(act8), .h_sync_out(hs8), .v_sync_out(vs8)
   );

   fb_scanout #(.BPP(16)) dut16 (
      .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
      .active_draw(active_draw), .h_sync(h_sync), .v_sync(v_sync),
      .new_frame(new_frame), .scroll_x(scroll_x), .scroll_y(scroll_y),
      .scroll_wen(scroll_wen), .mem_addr(addr16), .mem_ren(ren16),
      .mem_rdata(rdata16), .red(r16), .green(g16), .blue(b16),
      .active_draw_out(act16), .h_sync_out(hs16), .v_sync_out(vs16)
   );

   // two-cycle read latency memory model
   always @(posedge clk) begin
      pipe8_0  <= mem[addr8[14:0]];
      pipe8_1  <= pipe8_0;
      pipe16_0 <= mem[addr16[14:0]];
      pipe16_1 <= pipe16_0;
   end
   assign rdata8  = pipe8_1;
   assign rdata16 = pipe16_1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      h_count     = '0;
      v_count     = '0;
      active_draw = 1'b0;
      h_sync      = 1'b0;
      v_sync      = 1'b0;
   endtask

   task automatic scroll(input int x, input int y, input logic wen, input logic nf);
      scroll_x   = 16'(x);
      scroll_y   = 16'(y);
      scroll_wen = wen;
      new_frame  = nf;
      tick();
      scroll_wen = 1'b0;
      new_frame  = 1'b0;
   endtask

   // One-cycle pixel; checks the request at +2, quiet outputs at +4 and
   // colour/timing at +5.
   task automatic pixel(input string tag, input int h, input int v,
                        input logic act, input logic hs, input logic vs,
                        input logic exp_ren,
                        input logic [31:0] ea8, input logic [23:0] rgb8,
                        input logic [31:0] ea16, input logic [23:0] rgb16);
      h_count     = 11'(h);
      v_count     = 10'(v);
      active_draw = act;
      h_sync      = hs;
      v_sync      = vs;
      tick();
      idle();
      tick();
      check({tag, "/ren"}, 64'({ren8, ren16}), 64'({exp_ren, exp_ren}));
      check({tag, "/addr8"}, 64'(addr8), 64'(ea8));
      check({tag, "/addr16"}, 64'(addr16), 64'(ea16));
      tick();
      tick();
      check({tag, "/early"}, 64'({act8, hs8, vs8, r8, g8, b8}), 64'(0));
      tick();
      check({tag, "/rgb8"}, 64'({r8, g8, b8}), 64'(rgb8));
      check({tag, "/rgb16"}, 64'({r16, g16, b16}), 64'(rgb16));
      check({tag, "/timing"}, 64'({act8, hs8, vs8, act16, hs16, vs16}),
            64'({act, hs, vs, act, hs, vs}));
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = '0;
      rst        = 1'b1;
      scroll_x   = '0;
      scroll_y   = '0;
      scroll_wen = 1'b0;
      new_frame  = 1'b0;
      idle();
      tick();
      tick();
      tick();
      check("reset_addr", 64'({addr8, addr16}), 64'(0));
      check("reset_out", 64'({ren8, r8, g8, b8, act8, hs8, vs8, ren16, r16, g16, b16, act16, hs16, vs16}), 64'(0));
      rst = 1'b0;
      tick();

      // colour expansion and lane select
      mem['h300] = 32'h0000_00FF;
      pixel("white", 0, 0, 1, 0, 0, 1, 'h300, 24'hFFFFFF, 'h300, 24'h001CFF);
      mem['h300] = 32'h00E0_0000;
      pixel("lane8", 8, 0, 1, 1, 0, 1, 'h300, 24'hFF0000, 'h301, 24'h000000);
      mem['h300] = 32'h07E0_0000;
      pixel("lane16", 4, 0, 1, 0, 1, 1, 'h300, 24'h000000, 'h300, 24'h00FF00);

      // blanking: in-range coordinates but inactive -> black, address held
      mem['h300] = 32'h0000_00FF;
      pixel("blank", 0, 0, 0, 1, 1, 0, 'h300, 24'h0, 'h300, 24'h0);

      // last framebuffer pixel, then out-of-range rows/columns
      mem['h3B3F] = 32'hFF00_0000;
      mem['h737F] = 32'hFFFF_0000;
      pixel("corner", 1276, 716, 1, 0, 0, 1, 'h3B3F, 24'hFFFFFF, 'h737F, 24'hFFFFFF);
      pixel("oor_v", 0, 720, 1, 0, 0, 0, 'h3B3F, 24'h0, 'h737F, 24'h0);
      pixel("oor_h", 1280, 0, 1, 0, 0, 0, 'h3B3F, 24'h0, 'h737F, 24'h0);

      // scroll: pending only becomes live on new_frame
      scroll(319, 0, 1, 0);
      pixel("scr_pend", 4, 0, 1, 0, 0, 1, 'h300, 24'h0, 'h300, 24'h0);
      scroll(0, 0, 0, 1);
      pixel("scr_wrapx", 4, 0, 1, 0, 0, 1, 'h300, 24'hFFFFFF, 'h300, 24'h001CFF);
      scroll(319, 179, 1, 0);
      pixel("scr_midfrm", 4, 4, 1, 0, 0, 1, 'h350, 24'h0, 'h3A0, 24'h0);
      scroll(0, 0, 0, 1);
      pixel("scr_wrapy", 4, 4, 1, 0, 0, 1, 'h300, 24'hFFFFFF, 'h300, 24'h001CFF);
      scroll(320, 0, 1, 0);
      scroll(0, 180, 1, 0);
      scroll(0, 0, 0, 1);
      pixel("scr_ignore", 4, 4, 1, 0, 0, 1, 'h300, 24'hFFFFFF, 'h300, 24'h001CFF);
      scroll(0, 0, 1, 1);
      pixel("scr_bypass", 4, 4, 1, 0, 0, 1, 'h350, 24'h0, 'h3A0, 24'h0);
      scroll(0, 0, 0, 1);
      pixel("scr_pendsame", 4, 4, 1, 0, 0, 1, 'h350, 24'h0, 'h3A0, 24'h0);

      // reset mid-line with a white pixel in flight
      h_count     = '0;
      v_count     = '0;
      active_draw = 1'b1;
      h_sync      = 1'b1;
      v_sync      = 1'b1;
      tick();
      idle();
      tick();
      rst = 1'b1;
      #1;
      check("rstmid_addr", 64'({addr8, addr16}), 64'(0));
      check("rstmid_out", 64'({ren8, r8, g8, b8, act8, hs8, vs8, ren16, r16, g16, b16, act16, hs16, vs16}), 64'(0));
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("rstmid_flush", 64'({r8, g8, b8, act8, hs8, vs8, r16, g16, b16}), 64'(0));
      pixel("rst_refill", 0, 0, 1, 0, 0, 1, 'h300, 24'hFFFFFF, 'h300, 24'h001CFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
